// File: rtl/ifetch_sequencer_pkg.sv
// Shared types for the instruction-fetch sequencer: FSM states, thread id type, wrap helper.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ifetch_sequencer_pkg;

  localparam int NTHREADS = 4;
  localparam int THREAD_W = 2;

  typedef logic [THREAD_W-1:0] tid_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_REL  = 2'd2,
    ST_OUT  = 2'd3
  } iseq_state_e;

  // Thread id arithmetic wraps modulo NTHREADS (3 -> 0).
  function automatic tid_t tid_wrap_add(tid_t base, int off);
    return base + tid_t'(off);
  endfunction

endpackage

// File: rtl/ifetch_sequencer_if.sv
// Bus bundle between the sequencer and its neighbours: FETCH request/ack, decode valid/ready, redirect.
// Latency: n/a (wires only).
// Backpressure: instr_ready stalls the decode port; ack completes a FETCH request.
interface ifetch_sequencer_if;
  import ifetch_sequencer_pkg::*;

  // FETCH side
  logic        f_enable;
  logic        write_mode;
  logic [31:0] addr;
  logic [31:0] data_i;
  tid_t        thread;
  logic [31:0] data_o;
  logic        ack;
  // decode side
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  tid_t        instr_thread;
  // branch redirect
  logic        redir_valid;
  tid_t        redir_thread;
  logic [31:0] redir_pc;

  modport master (
    output f_enable, write_mode, addr, data_i, thread,
    input  data_o, ack,
    output instr_valid, instr, instr_pc, instr_thread,
    input  instr_ready,
    input  redir_valid, redir_thread, redir_pc
  );

  modport slave (
    input  f_enable, write_mode, addr, data_i, thread,
    output data_o, ack,
    input  instr_valid, instr, instr_pc, instr_thread,
    output instr_ready,
    output redir_valid, redir_thread, redir_pc
  );

endinterface

// File: rtl/ifetch_sequencer_rr_pick4.sv
// Round-robin pick of one thread from a 4-bit eligibility mask, starting just after `last`.
// Latency: combinational.
// Backpressure: none; any=0 when the mask is empty (grant then meaningless).
module rr_pick4
  import ifetch_sequencer_pkg::*;
(
  input  logic [NTHREADS-1:0] mask,
  input  tid_t                last,
  output tid_t                grant,
  output logic                any
);

  // Scan farthest-to-nearest so the nearest eligible thread after `last` overrides; `last` itself is tried last.
  always_comb begin
    grant = last;
    for (int i = NTHREADS; i >= 1; i--) begin
      if (mask[tid_wrap_add(last, i)]) begin
        grant = tid_wrap_add(last, i);
      end
    end
  end

  assign any = |mask;

endmodule

// File: rtl/ifetch_sequencer.sv
// Per-thread PC owner that issues FETCH reads round-robin and hands fetched words to decode (ISEQ_PERF_EN adds counters).
// Latency: issue registered; instr_valid rises FETCH latency + 2 cycles after f_enable; >=2 idle cycles between fetches.
// Backpressure: holds the word in OUT until instr_ready; ack timeout faults the thread and drops the request.
module ifetch_sequencer
  import ifetch_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned PC_STEP     = 4,
  parameter int unsigned ACK_TIMEOUT = 255
)(
  input  logic                clk,
  input  logic                rst,
  input  logic [NTHREADS-1:0] thread_en,
  ifetch_sequencer_if.master  bus,
  output logic [NTHREADS-1:0] fault,
  output logic [31:0]         perf_instr,
  output logic [31:0]         perf_stall
);

  localparam logic [31:0] STEP     = 32'(PC_STEP);
  // timer_q counts WAIT cycles already spent, so the abort fires at the end of the ACK_TIMEOUT-th one.
  localparam logic [15:0] TMO_LAST = 16'(ACK_TIMEOUT - 1);

  iseq_state_e         state_q, state_d;
  tid_t                last_q, last_d;
  logic [31:0]         pc_q [NTHREADS];
  logic [31:0]         pc_d [NTHREADS];
  logic                f_enable_q, f_enable_d;
  logic [31:0]         addr_q, addr_d;
  tid_t                thread_q, thread_d;
  logic [15:0]         timer_q, timer_d;
  logic                squash_q, squash_d;
  logic [31:0]         instr_q, instr_d;
  logic                instr_valid_q, instr_valid_d;
  logic [NTHREADS-1:0] fault_q, fault_d;

  tid_t                pick_id;
  logic                pick_any;
  logic                redir_hit;
  logic                accept;

  rr_pick4 u_pick (
    .mask  (thread_en & ~fault_q),
    .last  (last_q),
    .grant (pick_id),
    .any   (pick_any)
  );

  assign redir_hit = bus.redir_valid && (bus.redir_thread == thread_q);
  assign accept    = instr_valid_q && bus.instr_ready;

  // Next-state, PC update, fault bookkeeping; redirect is applied last so it overrides step and fault-set.
  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    pc_d          = pc_q;
    f_enable_d    = f_enable_q;
    addr_d        = addr_q;
    thread_d      = thread_q;
    timer_d       = timer_q;
    squash_d      = squash_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    fault_d       = fault_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          last_d     = pick_id;
          thread_d   = pick_id;
          // A same-cycle redirect of the chosen thread is fetched directly rather than fetching a dead PC.
          addr_d     = (bus.redir_valid && bus.redir_thread == pick_id) ? bus.redir_pc : pc_q[pick_id];
          f_enable_d = 1'b1;
          timer_d    = '0;
          squash_d   = 1'b0;
          state_d    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        timer_d = timer_q + 16'd1;
        if (redir_hit) squash_d = 1'b1;
        if (bus.ack) begin
          instr_d = bus.data_o;
          state_d = ST_REL;
        end else if (timer_q == TMO_LAST) begin
          fault_d[thread_q] = 1'b1;
          f_enable_d        = 1'b0;
          state_d           = ST_IDLE;
        end
      end
      ST_REL: begin
        // One extra f_enable cycle lets FETCH leave its done state with ack low.
        f_enable_d = 1'b0;
        if (squash_q || redir_hit) begin
          state_d = ST_IDLE;
        end else begin
          instr_valid_d = 1'b1;
          state_d       = ST_OUT;
        end
      end
      ST_OUT: begin
        if (accept) pc_d[thread_q] = pc_q[thread_q] + STEP;
        if (accept || redir_hit) begin
          instr_valid_d = 1'b0;
          state_d       = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.redir_valid) begin
      pc_d[bus.redir_thread]    = bus.redir_pc;
      fault_d[bus.redir_thread] = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      last_q        <= tid_t'(NTHREADS - 1);
      for (int t = 0; t < NTHREADS; t++) pc_q[t] <= RESET_PC;
      f_enable_q    <= 1'b0;
      addr_q        <= '0;
      thread_q      <= '0;
      timer_q       <= '0;
      squash_q      <= 1'b0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      fault_q       <= '0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      pc_q          <= pc_d;
      f_enable_q    <= f_enable_d;
      addr_q        <= addr_d;
      thread_q      <= thread_d;
      timer_q       <= timer_d;
      squash_q      <= squash_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      fault_q       <= fault_d;
    end
  end

  assign bus.f_enable     = f_enable_q;
  assign bus.write_mode   = 1'b0;
  assign bus.addr         = addr_q;
  assign bus.data_i       = '0;
  assign bus.thread       = thread_q;
  assign bus.instr_valid  = instr_valid_q;
  assign bus.instr        = instr_q;
  // addr/thread only change at the next issue, which cannot happen before OUT is left.
  assign bus.instr_pc     = addr_q;
  assign bus.instr_thread = thread_q;
  assign fault            = fault_q;

`ifdef ISEQ_PERF_EN
  logic [31:0] perf_instr_q, perf_instr_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  // Saturating accept and stall counters.
  always_comb begin
    perf_instr_d = perf_instr_q;
    perf_stall_d = perf_stall_q;
    if (accept && perf_instr_q != 32'hFFFF_FFFF) perf_instr_d = perf_instr_q + 32'd1;
    if (instr_valid_q && !bus.instr_ready && perf_stall_q != 32'hFFFF_FFFF) perf_stall_d = perf_stall_q + 32'd1;
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_instr_q <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_instr_q <= perf_instr_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_instr = perf_instr_q;
  assign perf_stall = perf_stall_q;
`else
  assign perf_instr = '0;
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_ifetch_sequencer.sv
// Directed bench for ifetch_sequencer: round-robin order, PC stepping, stall hold, redirect squash, timeout fault, reset.
// Latency: ACK_TIMEOUT=8 so the timeout path is short.
// Backpressure: instr_ready driven directly by the bench.
module tb_ifetch_sequencer;
  import ifetch_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  thread_en = 4'b0000;
  logic [3:0]  fault;
  logic [31:0] perf_instr;
  logic [31:0] perf_stall;
  int          checks = 0;
  int          failures = 0;

  ifetch_sequencer_if bus ();

  ifetch_sequencer #(.ACK_TIMEOUT(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .thread_en  (thread_en),
    .bus        (bus),
    .fault      (fault),
    .perf_instr (perf_instr),
    .perf_stall (perf_stall)
  );

  always #5 clk = ~clk;

`ifdef ISEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.ack = 1'b0;
    bus.redir_valid = 1'b0;
    step();
    step();
    chk("rst_fen", bus.f_enable, 0);
    chk("rst_valid", bus.instr_valid, 0);
    chk("rst_fault", fault, 0);
    chk("rst_addr", bus.addr, 0);
    chk("rst_perf_instr", perf_instr, 0);
    rst = 1'b0;
  endtask

  task automatic wait_issue(input logic [31:0] exp_pc, input logic [1:0] exp_thr);
    int n = 0;
    while (bus.f_enable !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("issue_seen", bus.f_enable, 1);
    chk("issue_addr", bus.addr, exp_pc);
    chk("issue_thread", bus.thread, exp_thr);
    chk("issue_wr", bus.write_mode, 0);
  endtask

  // Raise ack `lat` cycles after the request was first seen; returns with the DUT in REL.
  task automatic give_ack(input logic [31:0] word, input int lat);
    repeat (lat) step();
    bus.ack = 1'b1;
    bus.data_o = word;
    step();
    bus.ack = 1'b0;
    bus.data_o = '0;
  endtask

  // Full fetch with instr_ready=1: issue, ack, release, present, accept.
  task automatic fetch_and_check(input logic [31:0] word, input int lat,
                                 input logic [31:0] exp_pc, input logic [1:0] exp_thr);
    wait_issue(exp_pc, exp_thr);
    give_ack(word, lat);
    chk("rel_fen_hold", bus.f_enable, 1);
    chk("rel_no_valid", bus.instr_valid, 0);
    step();
    chk("out_valid", bus.instr_valid, 1);
    chk("out_fen_low", bus.f_enable, 0);
    chk("out_instr", bus.instr, word);
    chk("out_pc", bus.instr_pc, exp_pc);
    chk("out_thread", bus.instr_thread, exp_thr);
    step();
    chk("acc_valid_low", bus.instr_valid, 0);
  endtask

  initial begin
    bus.ack = 1'b0;
    bus.data_o = '0;
    bus.instr_ready = 1'b1;
    bus.redir_valid = 1'b0;
    bus.redir_thread = '0;
    bus.redir_pc = '0;

    // T1: single thread, ack latency 3
    thread_en = 4'b0001;
    do_reset();
    fetch_and_check(32'hA000_0000, 3, 32'h0, 2'd0);
    fetch_and_check(32'hA000_0004, 3, 32'h4, 2'd0);
    fetch_and_check(32'hA000_0008, 3, 32'h8, 2'd0);

    // T2: all threads round-robin
    thread_en = 4'b1111;
    do_reset();
    fetch_and_check(32'hB000_0000, 1, 32'h0, 2'd0);
    fetch_and_check(32'hB000_0001, 1, 32'h0, 2'd1);
    fetch_and_check(32'hB000_0002, 1, 32'h0, 2'd2);
    fetch_and_check(32'hB000_0003, 1, 32'h0, 2'd3);
    fetch_and_check(32'hB000_0004, 1, 32'h4, 2'd0);

    // T3: decode stalls 5 cycles
    thread_en = 4'b0001;
    do_reset();
    bus.instr_ready = 1'b0;
    wait_issue(32'h0, 2'd0);
    give_ack(32'hC0DE_0003, 2);
    step();
    chk("t3_valid", bus.instr_valid, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_valid", bus.instr_valid, 1);
      chk("t3_hold_instr", bus.instr, 32'hC0DE_0003);
      chk("t3_hold_pc", bus.instr_pc, 32'h0);
    end
    bus.instr_ready = 1'b1;
    step();
    chk("t3_accept", bus.instr_valid, 0);
    chk("t3_perf_stall", perf_stall, PERF ? 32'd5 : 32'd0);
    chk("t3_perf_instr", perf_instr, PERF ? 32'd1 : 32'd0);
    fetch_and_check(32'hC0DE_0007, 1, 32'h4, 2'd0);

    // T4: redirect during WAIT squashes the fetch
    do_reset();
    wait_issue(32'h0, 2'd0);
    bus.redir_valid = 1'b1;
    bus.redir_thread = 2'd0;
    bus.redir_pc = 32'h100;
    step();
    bus.redir_valid = 1'b0;
    give_ack(32'hDEAD_0000, 1);
    chk("t4_rel_fen", bus.f_enable, 1);
    step();
    chk("t4_squash_valid", bus.instr_valid, 0);
    chk("t4_squash_fen", bus.f_enable, 0);
    step();
    chk("t4_squash_valid2", bus.instr_valid, 0);
    fetch_and_check(32'hD000_0100, 1, 32'h100, 2'd0);
    fetch_and_check(32'hD000_0104, 1, 32'h104, 2'd0);

    // T5: no ack -> timeout after 8 WAIT cycles, thread skipped, redirect clears fault
    do_reset();
    wait_issue(32'h0, 2'd0);
    repeat (7) step();
    chk("t5_still_wait", bus.f_enable, 1);
    chk("t5_no_fault_yet", fault, 4'b0000);
    step();
    chk("t5_fault", fault, 4'b0001);
    chk("t5_fen_drop", bus.f_enable, 0);
    repeat (3) step();
    chk("t5_skipped", bus.f_enable, 0);
    chk("t5_no_valid", bus.instr_valid, 0);
    thread_en = 4'b0011;
    fetch_and_check(32'hE000_0001, 1, 32'h0, 2'd1);
    bus.redir_valid = 1'b1;
    bus.redir_thread = 2'd0;
    bus.redir_pc = 32'h200;
    step();
    bus.redir_valid = 1'b0;
    chk("t5_fault_clr", fault, 4'b0000);
    fetch_and_check(32'hE000_0005, 1, 32'h4, 2'd1);
    fetch_and_check(32'hE000_0200, 1, 32'h200, 2'd0);

    // T6: reset while in WAIT
    thread_en = 4'b1111;
    do_reset();
    fetch_and_check(32'hF000_0000, 1, 32'h0, 2'd0);
    wait_issue(32'h0, 2'd1);
    rst = 1'b1;
    step();
    chk("t6_fen", bus.f_enable, 0);
    chk("t6_valid", bus.instr_valid, 0);
    chk("t6_addr", bus.addr, 0);
    rst = 1'b0;
    fetch_and_check(32'hF100_0000, 1, 32'h0, 2'd0);
    fetch_and_check(32'hF100_0001, 1, 32'h0, 2'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
